// File: rtl/gb_mem_pkg.sv
// Shared memory-map constants and DMA state encoding for the OAM DMA controller.
// Configuration macro: OAM_DMA_ECHO_MAP_EN
//   defined   -> source pages 0xE0..0xFF are read from page - 0x20 (WRAM echo)
//   undefined -> the source page is used unmodified
package gb_mem_pkg;

  localparam logic [15:0] DMA_REG_ADDR  = 16'hFF46;
  localparam logic [15:0] OAM_BASE      = 16'hFE00;
  localparam logic [15:0] HRAM_BASE     = 16'hFF80;
  localparam logic [7:0]  OPEN_BUS_DATA = 8'hFF;

  localparam logic [7:0]  ECHO_PAGE_LO  = 8'hE0;
  localparam logic [7:0]  ECHO_OFFSET   = 8'h20;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StRead,
    StWrite
  } dma_state_t;

  // Translate the page written to the trigger register into the page actually read.
  function automatic logic [7:0] map_src_page(input logic [7:0] page);
`ifdef OAM_DMA_ECHO_MAP_EN
    return (page >= ECHO_PAGE_LO) ? page - ECHO_OFFSET : page;
`else
    return page;
`endif
  endfunction

endpackage

// File: rtl/oam_dma_bus_mux.sv
// Combinational selection of the memory-side bus and the CPU read data.
// Ports:
//   state_i      current DMA FSM state
//   cpu_own_i    CPU holds the bus this cycle while a transfer is active
//   cpu_*_i      CPU address / write data / strobes
//   src_addr_i   DMA source address for the READ phase
//   dst_addr_i   DMA destination address for the WRITE phase
//   byte_i       byte captured during READ, written during WRITE
//   mem_rdata_i  memory read data (combinational)
//   cpu_rdata_o  data returned to the CPU (open-bus value when blocked)
//   mem_*_o      memory address / write data / strobes
module oam_dma_bus_mux import gb_mem_pkg::*; #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  dma_state_t            state_i,
  input  logic                  cpu_own_i,
  input  logic [ADDR_WIDTH-1:0] cpu_addr_i,
  input  logic [DATA_WIDTH-1:0] cpu_wdata_i,
  input  logic                  cpu_wr_en_i,
  input  logic                  cpu_rd_en_i,
  input  logic [ADDR_WIDTH-1:0] src_addr_i,
  input  logic [ADDR_WIDTH-1:0] dst_addr_i,
  input  logic [DATA_WIDTH-1:0] byte_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic [DATA_WIDTH-1:0] cpu_rdata_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  output logic                  mem_wr_en_o,
  output logic                  mem_rd_en_o
);

  always_comb begin
    mem_addr_o  = '0;
    mem_wdata_o = byte_i;
    mem_wr_en_o = 1'b0;
    mem_rd_en_o = 1'b0;
    cpu_rdata_o = DATA_WIDTH'(OPEN_BUS_DATA);

    if (state_i == StIdle || cpu_own_i) begin
      mem_addr_o  = cpu_addr_i;
      mem_wdata_o = cpu_wdata_i;
      mem_wr_en_o = cpu_wr_en_i;
      mem_rd_en_o = cpu_rd_en_i;
      cpu_rdata_o = mem_rdata_i;
    end else begin
      case (state_i)
        StRead: begin
          mem_addr_o  = src_addr_i;
          mem_rd_en_o = 1'b1;
        end
        StWrite: begin
          mem_addr_o  = dst_addr_i;
          mem_wr_en_o = 1'b1;
        end
        default: ;  // START is a bus-idle setup cycle
      endcase
    end
  end

endmodule

// File: rtl/oam_dma_ctrl.sv
// OAM DMA controller: arbitrates the unified memory between the CPU and a DMA engine that
// copies DMA_LEN bytes from {page,8'h00} to OAM_BASE, one byte every two clocks, after a
// CPU write to DMA_REG_ADDR. While active, only HRAM accesses and trigger writes reach memory.
// Configuration macro: OAM_DMA_ECHO_MAP_EN (echo-page source remap, see gb_mem_pkg).
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   cpu_*_i/_o     CPU bus (address, write data, strobes, read data)
//   mem_*_o/_i     unified memory bus (read data combinational)
//   dma_active_o   transfer in progress
//   dma_done_o     one-cycle pulse after the final OAM write
module oam_dma_ctrl #(
  parameter int unsigned           ADDR_WIDTH   = 16,
  parameter int unsigned           DATA_WIDTH   = 8,
  parameter int unsigned           DMA_LEN      = 160,
  parameter logic [ADDR_WIDTH-1:0] DMA_REG_ADDR = gb_mem_pkg::DMA_REG_ADDR,
  parameter logic [ADDR_WIDTH-1:0] OAM_BASE     = gb_mem_pkg::OAM_BASE,
  parameter logic [ADDR_WIDTH-1:0] HRAM_BASE    = gb_mem_pkg::HRAM_BASE
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [ADDR_WIDTH-1:0] cpu_addr_i,
  input  logic [DATA_WIDTH-1:0] cpu_wdata_i,
  input  logic                  cpu_wr_en_i,
  input  logic                  cpu_rd_en_i,
  output logic [DATA_WIDTH-1:0] cpu_rdata_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  output logic                  mem_wr_en_o,
  output logic                  mem_rd_en_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  dma_active_o,
  output logic                  dma_done_o
);
  import gb_mem_pkg::*;

  localparam logic [7:0] LastIdx = 8'(DMA_LEN - 1);

  dma_state_t            state_q;
  logic [7:0]            idx_q;
  logic [7:0]            page_q;
  logic [DATA_WIDTH-1:0] byte_q;
  logic                  active_q;
  logic                  done_q;

  logic                  dma_reg_wr;
  logic                  hram_acc;
  logic                  cpu_own;
  logic [ADDR_WIDTH-1:0] src_addr;
  logic [ADDR_WIDTH-1:0] dst_addr;

  assign dma_reg_wr = cpu_wr_en_i && (cpu_addr_i == DMA_REG_ADDR);
  assign hram_acc   = (cpu_wr_en_i || cpu_rd_en_i) && (cpu_addr_i >= HRAM_BASE);

  // A restart during WRITE leaves the bus to the pending OAM write so that byte still lands;
  // the trigger write is forwarded to memory in every other active state.
  assign cpu_own    = hram_acc || (dma_reg_wr && state_q != StWrite);

  // Source low byte is idx itself: no carry into the page.
  assign src_addr   = ADDR_WIDTH'({map_src_page(page_q), idx_q});
  assign dst_addr   = OAM_BASE + ADDR_WIDTH'(idx_q);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      page_q   <= '0;
      byte_q   <= '0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (dma_reg_wr) begin
        // Trigger from idle, or restart while active: restart wins over completion.
        page_q   <= cpu_wdata_i[7:0];
        idx_q    <= '0;
        state_q  <= StStart;
        active_q <= 1'b1;
      end else if (state_q != StIdle && !hram_acc) begin
        case (state_q)
          StStart: state_q <= StRead;
          StRead: begin
            byte_q  <= mem_rdata_i;
            state_q <= StWrite;
          end
          StWrite: begin
            if (idx_q == LastIdx) begin
              state_q  <= StIdle;
              active_q <= 1'b0;
              done_q   <= 1'b1;
            end else begin
              idx_q   <= idx_q + 8'd1;
              state_q <= StRead;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  oam_dma_bus_mux #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_bus_mux (
    .state_i     (state_q),
    .cpu_own_i   (cpu_own),
    .cpu_addr_i  (cpu_addr_i),
    .cpu_wdata_i (cpu_wdata_i),
    .cpu_wr_en_i (cpu_wr_en_i),
    .cpu_rd_en_i (cpu_rd_en_i),
    .src_addr_i  (src_addr),
    .dst_addr_i  (dst_addr),
    .byte_i      (byte_q),
    .mem_rdata_i (mem_rdata_i),
    .cpu_rdata_o (cpu_rdata_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_wr_en_o (mem_wr_en_o),
    .mem_rd_en_o (mem_rd_en_o)
  );

  assign dma_active_o = active_q;
  assign dma_done_o   = done_q;

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Directed/randomized bench for oam_dma_ctrl with a behavioural memory and expected-value model.
module tb_oam_dma_ctrl;

  localparam int Len     = 160;
  localparam int XferLat = 2 * Len + 1;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_wr_en;
  logic        cpu_rd_en;
  logic [7:0]  cpu_rdata;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_wr_en;
  logic        mem_rd_en;
  logic [7:0]  mem_rdata;
  logic        dma_active;
  logic        dma_done;

  always #5 clk = ~clk;

  oam_dma_ctrl u_dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .cpu_addr_i   (cpu_addr),
    .cpu_wdata_i  (cpu_wdata),
    .cpu_wr_en_i  (cpu_wr_en),
    .cpu_rd_en_i  (cpu_rd_en),
    .cpu_rdata_o  (cpu_rdata),
    .mem_addr_o   (mem_addr),
    .mem_wdata_o  (mem_wdata),
    .mem_wr_en_o  (mem_wr_en),
    .mem_rd_en_o  (mem_rd_en),
    .mem_rdata_i  (mem_rdata),
    .dma_active_o (dma_active),
    .dma_done_o   (dma_done)
  );

  // Asynchronous memory: combinational read, write on clock edge; pl_* is a bench preload port.
  logic [7:0]  mem [0:65535];
  logic        pl_en = 1'b0;
  logic [15:0] pl_addr;
  logic [7:0]  pl_data;

  assign mem_rdata = mem_rd_en ? mem[mem_addr] : 8'h00;

  always @(posedge clk) begin
    if (mem_wr_en) mem[mem_addr] <= mem_wdata;
    if (pl_en) mem[pl_addr] <= pl_data;
  end

  // Expected memory contents, kept independently of the DUT.
  logic [7:0] ref_mem [int];

  int checks   = 0;
  int errors   = 0;
  int cyc      = 0;
  int done_cnt = 0;

  always @(negedge clk) if (dma_done === 1'b1) done_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic preload(input logic [15:0] a, input logic [7:0] d);
    pl_en   = 1'b1;
    pl_addr = a;
    pl_data = d;
    tick();
    pl_en   = 1'b0;
    ref_mem[int'(a)] = d;
  endtask

  // Random source bytes stay below the OAM sentinel so stray writes are visible.
  task automatic fill_page(input logic [7:0] page);
    for (int i = 0; i < Len; i++) preload({page, 8'(i)}, 8'($urandom_range(0, 8'hDF)));
  endtask

  task automatic cpu_wr(input logic [15:0] a, input logic [7:0] d);
    cpu_addr  = a;
    cpu_wdata = d;
    cpu_wr_en = 1'b1;
    tick();
    cpu_wr_en = 1'b0;
  endtask

  task automatic cpu_rd(input logic [15:0] a, output logic [7:0] d);
    cpu_addr  = a;
    cpu_rd_en = 1'b1;
    #2;
    d = cpu_rdata;
    tick();
    cpu_rd_en = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Waits (bounded) for dma_done and checks latency counted from the trigger edge.
  task automatic wait_done(input int start, input int exp_lat, input string tag);
    int n = 0;
    while (dma_done !== 1'b1 && n < 2000) begin
      tick();
      n++;
    end
    check({tag, " latency"}, 32'(cyc - start), 32'(exp_lat));
    check({tag, " active at done"}, 32'(dma_active), 32'd0);
    tick();
    check({tag, " done pulse width"}, 32'(dma_done), 32'd0);
  endtask

  task automatic check_oam(input logic [7:0] page, input int upto, input string tag);
    for (int i = 0; i < Len; i++) begin
      logic [15:0] dst;
      logic [7:0]  exp;
      dst = 16'hFE00 + 16'(i);
      exp = (i < upto) ? ref_mem[int'({page, 8'(i)})] : 8'hEE;
      check($sformatf("%s oam[%0d]", tag, i), 32'(mem[dst]), 32'(exp));
    end
  endtask

  initial begin
    logic [7:0]  rd;
    logic [7:0]  src_page;
    logic [15:0] h_addr [4];
    logic [7:0]  h_data [4];
    int          start;
    int          nh;
    int          d0;

    rst       = 1'b1;
    cpu_addr  = '0;
    cpu_wdata = '0;
    cpu_wr_en = 1'b0;
    cpu_rd_en = 1'b0;
    idle(3);
    rst = 1'b0;
    check("reset active", 32'(dma_active), 32'd0);
    check("reset done", 32'(dma_done), 32'd0);

    // Idle passthrough.
    preload(16'h1234, 8'hA5);
    cpu_addr  = 16'h1234;
    cpu_rd_en = 1'b1;
    #2;
    check("idle mem_addr", 32'(mem_addr), 32'h1234);
    check("idle mem_rd_en", 32'(mem_rd_en), 32'd1);
    check("idle rdata", 32'(cpu_rdata), 32'hA5);
    tick();
    cpu_rd_en = 1'b0;

    // 1: basic transfer from C0 with the i^0x5A pattern.
    for (int i = 0; i < Len; i++) preload({8'hC0, 8'(i)}, 8'(i) ^ 8'h5A);
    cpu_wr(16'hFF46, 8'hC0);
    start = cyc;
    check("t1 active after trigger", 32'(dma_active), 32'd1);
    wait_done(start, XferLat, "t1");
    check("t1 done count", 32'(done_cnt), 32'd1);
    check_oam(8'hC0, Len, "t1");

    // 2/3: blocked accesses do not stall; each HRAM access stalls one cycle.
    fill_page(8'hC2);
    preload(16'h8000, 8'h12);
    nh = int'($urandom_range(1, 4));
    for (int j = 0; j < nh; j++) begin
      h_addr[j] = 16'hFFA0 + 16'(j * 3);
      h_data[j] = 8'($urandom);
    end
    cpu_wr(16'hFF46, 8'hC2);
    start = cyc;
    idle(20);
    cpu_rd(16'h8000, rd);
    check("t2 blocked read", 32'(rd), 32'hFF);
    cpu_wr(16'hC000, 8'h33);
    cpu_wr(16'hFF90, 8'h77);
    ref_mem[int'(16'hFF90)] = 8'h77;
    cpu_rd(16'hFF90, rd);
    check("t3 hram readback", 32'(rd), 32'h77);
    for (int j = 0; j < nh; j++) cpu_wr(h_addr[j], h_data[j]);
    for (int j = 0; j < nh; j++) begin
      cpu_rd(h_addr[j], rd);
      check($sformatf("t3 hram rand %0d", j), 32'(rd), 32'(h_data[j]));
    end
    wait_done(start, XferLat + 2 + 2 * nh, "t3");
    check("t2 dropped write", 32'(mem[16'hC000]), 32'(ref_mem[int'(16'hC000)]));
    check_oam(8'hC2, Len, "t2");

    // 4: restart at idx 50 with page D0.
    fill_page(8'hD0);
    d0 = done_cnt;
    cpu_wr(16'hFF46, 8'hC0);
    idle(101);
    cpu_wr(16'hFF46, 8'hD0);
    start = cyc;
    check("t4 active after restart", 32'(dma_active), 32'd1);
    wait_done(start, XferLat, "t4");
    check("t4 single done", 32'(done_cnt), 32'(d0 + 1));
    check("t4 reg forwarded", 32'(mem[16'hFF46]), 32'hD0);
    check_oam(8'hD0, Len, "t4");

    // 5: reset at idx 80 leaves 80 bytes written.
    for (int i = 0; i < Len; i++) preload(16'hFE00 + 16'(i), 8'hEE);
    fill_page(8'hC1);
    d0 = done_cnt;
    cpu_wr(16'hFF46, 8'hC1);
    idle(161);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5 active after rst", 32'(dma_active), 32'd0);
    idle(400);
    check("t5 no done", 32'(done_cnt), 32'(d0));
    check_oam(8'hC1, 80, "t5");
    fill_page(8'hC3);
    cpu_wr(16'hFF46, 8'hC3);
    start = cyc;
    wait_done(start, XferLat, "t5 restart");
    check_oam(8'hC3, Len, "t5 restart");

    // 6: echo page mapping.
    fill_page(8'hC1);
    fill_page(8'hE1);
`ifdef OAM_DMA_ECHO_MAP_EN
    src_page = 8'hC1;
`else
    src_page = 8'hE1;
`endif
    cpu_wr(16'hFF46, 8'hE1);
    start = cyc;
    wait_done(start, XferLat, "t6");
    check_oam(src_page, Len, "t6");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
